// File: rtl/syscall_pkg.sv
// -----------------------------------------------------------------------------
// syscall_pkg
// Shared definitions for the console-input syscall block:
//   - MIPS $v0 codes for the read-type syscalls
//   - string length cap
//   - FSM state encoding
//   - ASCII byte constants used by the integer parser
//   - byte-lane enable helper for the data-memory write port
// -----------------------------------------------------------------------------
package syscall_pkg;

    localparam logic [31:0] SYS_READ_INT  = 32'd5;
    localparam logic [31:0] SYS_READ_STR  = 32'd8;
    localparam logic [31:0] SYS_READ_CHAR = 32'd12;

    localparam logic signed [31:0] MAX_STR_LEN = 32'sd1024;

    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INT_SKIP,
        ST_INT_DIG,
        ST_STR,
        ST_STR_NUL,
        ST_CHR,
        ST_DONE
    } state_t;

    // Whitespace skipped before an integer: space, tab, LF, CR.
    function automatic logic is_space(input logic [7:0] b);
        return (b == CH_SPACE) || (b == CH_TAB) || (b == CH_LF) || (b == CH_CR);
    endfunction

    // One-hot byte enable; address offset 0 selects lane [7:0].
    function automatic logic [3:0] lane_be(input logic [1:0] ofs);
        return 4'b0001 << ofs;
    endfunction

endpackage

// File: rtl/ascii_dec_acc.sv
// -----------------------------------------------------------------------------
// ascii_dec_acc
// Combinational decimal-digit test and accumulate step.
//   i_byte      : ASCII byte under test
//   i_acc       : current accumulator
//   o_is_digit  : i_byte is '0'..'9'
//   o_digit     : numeric value of the digit (meaningful only when o_is_digit)
//   o_acc_next  : i_acc*10 + digit, modulo 2^32
// -----------------------------------------------------------------------------
module ascii_dec_acc
    import syscall_pkg::*;
(
    input  logic [7:0]  i_byte,
    input  logic [31:0] i_acc,
    output logic        o_is_digit,
    output logic [31:0] o_digit,
    output logic [31:0] o_acc_next
);

    logic [31:0] w_times10;

    // acc*10 as (acc<<3)+(acc<<1); high bits drop off so the result wraps.
    assign w_times10  = {i_acc[28:0], 3'b000} + {i_acc[30:0], 1'b0};
    assign o_is_digit = (i_byte >= CH_ZERO) && (i_byte <= CH_NINE);
    assign o_digit    = {28'd0, i_byte[3:0]};
    assign o_acc_next = w_times10 + o_digit;

endmodule

// File: rtl/syscall_console_in.sv
// -----------------------------------------------------------------------------
// syscall_console_in
// Services read_int / read_string / read_char syscalls from a console byte
// stream. Stalls the pipeline while bytes are consumed, writes string bytes
// into data memory one byte per cycle, returns scalar results to $v0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   sys, regv, rega, rega1 syscall strobe with $v0, $a0, $a1
//   rx_data, rx_valid     console byte input
//   rx_ready              block accepts a byte this cycle (state-decoded)
//   stall                 freeze pipeline
//   mem_we/addr/wdata/be  byte write into word-addressed data memory
//   rf_we, rf_wdata       one-cycle write of $v0
//   busy                  FSM not idle
// -----------------------------------------------------------------------------
module syscall_console_in
    import syscall_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sys,
    input  logic [31:0] regv,
    input  logic [31:0] rega,
    input  logic [31:0] rega1,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        stall,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        busy
);

    state_t r_state;
    state_t w_next;

    logic [31:0] r_acc;
    logic        r_neg;
    logic [31:0] r_addr;
    logic [31:0] r_cnt;
    logic [31:0] r_result;
    logic        r_is_str;

    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;

    logic               w_code_hit;
    logic signed [31:0] w_len;
    logic signed [31:0] w_n;
    logic               w_is_digit;
    logic [31:0]        w_digit;
    logic [31:0]        w_acc_next;
    logic               w_is_space;

    ascii_dec_acc u_dec (
        .i_byte     (rx_data),
        .i_acc      (r_acc),
        .o_is_digit (w_is_digit),
        .o_digit    (w_digit),
        .o_acc_next (w_acc_next)
    );

    assign w_is_space = is_space(rx_data);
    assign w_code_hit = sys && ((regv == SYS_READ_INT) || (regv == SYS_READ_STR) ||
                                (regv == SYS_READ_CHAR));

    // $a1 is signed; anything above the cap is clamped.
    assign w_len = $signed(rega1);
    assign w_n   = (w_len > MAX_STR_LEN) ? MAX_STR_LEN : w_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Transitions out of byte-consuming states test rx_valid only: rx_ready
    // is already implied by being in such a state.
    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sys) begin
                    if (regv == SYS_READ_INT) begin
                        w_next = ST_INT_SKIP;
                    end else if (regv == SYS_READ_CHAR) begin
                        w_next = ST_CHR;
                    end else if (regv == SYS_READ_STR) begin
                        if (w_n <= 0)       w_next = ST_DONE;
                        else if (w_n == 1)  w_next = ST_STR_NUL;
                        else                w_next = ST_STR;
                    end
                end
            end
            ST_INT_SKIP: begin
                rx_ready = 1'b1;
                if (rx_valid && !w_is_space) begin
                    if ((rx_data == CH_MINUS) || w_is_digit) w_next = ST_INT_DIG;
                    else                                     w_next = ST_DONE;
                end
            end
            ST_INT_DIG: begin
                rx_ready = 1'b1;
                if (rx_valid && !w_is_digit) w_next = ST_DONE;
            end
            ST_STR: begin
                rx_ready = 1'b1;
                if (rx_valid && ((rx_data == CH_LF) || (r_cnt == 32'd1))) w_next = ST_STR_NUL;
            end
            ST_STR_NUL: w_next = ST_DONE;
            ST_CHR: begin
                rx_ready = 1'b1;
                if (rx_valid) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign stall    = busy || w_code_hit;
    assign rf_we    = (r_state == ST_DONE) && !r_is_str;
    assign rf_wdata = rf_we ? r_result : 32'd0;

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

    // Datapath. Memory writes are registered: a byte accepted in STR is
    // written in the following cycle, and the terminating NUL issued from
    // STR_NUL lands in the DONE cycle, which for strings carries no rf_we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= 32'd0;
            r_neg       <= 1'b0;
            r_addr      <= 32'd0;
            r_cnt       <= 32'd0;
            r_result    <= 32'd0;
            r_is_str    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
        end else begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_code_hit) begin
                        r_is_str <= (regv == SYS_READ_STR);
                        r_acc    <= 32'd0;
                        r_neg    <= 1'b0;
                        r_result <= 32'd0;
                        r_addr   <= rega;
                        r_cnt    <= w_n - 32'sd1;
                    end
                end
                ST_INT_SKIP: begin
                    if (rx_valid && !w_is_space) begin
                        if (rx_data == CH_MINUS)  r_neg    <= 1'b1;
                        else if (w_is_digit)      r_acc    <= w_digit;
                        else                      r_result <= 32'd0;
                    end
                end
                ST_INT_DIG: begin
                    if (rx_valid) begin
                        if (w_is_digit) r_acc    <= w_acc_next;
                        else            r_result <= r_neg ? -r_acc : r_acc;
                    end
                end
                ST_STR: begin
                    if (rx_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_addr[31:2], 2'b00};
                        r_mem_wdata <= {4{rx_data}};
                        r_mem_be    <= lane_be(r_addr[1:0]);
                        r_addr      <= r_addr + 32'd1;
                        r_cnt       <= r_cnt - 32'd1;
                    end
                end
                ST_STR_NUL: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= {r_addr[31:2], 2'b00};
                    r_mem_wdata <= {4{CH_NUL}};
                    r_mem_be    <= lane_be(r_addr[1:0]);
                end
                ST_CHR: begin
                    if (rx_valid) r_result <= {24'd0, rx_data};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_console_in.sv
module tb_syscall_console_in;

    logic        clk = 1'b0;
    logic        reset;
    logic        sys;
    logic [31:0] regv, rega, rega1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready, stall, mem_we, rf_we, busy;
    logic [31:0] mem_addr, mem_wdata, rf_wdata;
    logic [3:0]  mem_be;

    syscall_console_in dut (
        .clk(clk), .reset(reset), .sys(sys), .regv(regv), .rega(rega), .rega1(rega1),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .stall(stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .rf_we(rf_we), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_rf[$];
    logic [7:0]  rx_q[$];
    logic [31:0] last_rf = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ws(input logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
    endfunction

    function automatic logic dig(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // Parses an integer the way read_int is defined; returns bytes consumed.
    function automatic void model_int(input logic [7:0] s[$], output int consumed,
                                      output logic [31:0] res);
        int          i = 0;
        logic [31:0] acc = 0;
        logic        neg = 0;
        logic [7:0]  c;
        while (i < s.size() && ws(s[i])) i++;
        c = s[i]; i++;
        if (c == 8'h2D) neg = 1;
        else if (dig(c)) acc = {24'd0, c} - 32'd48;
        else begin consumed = i; res = 0; return; end
        while (i < s.size()) begin
            c = s[i]; i++;
            if (!dig(c)) break;
            acc = acc * 32'd10 + ({24'd0, c} - 32'd48);
        end
        consumed = i;
        res = neg ? (32'd0 - acc) : acc;
    endfunction

    function automatic void push_wr(input logic [31:0] a, input logic [7:0] c);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        w.be   = 4'b0001 << a[1:0];
        w.data = {4{c}};
        exp_wr.push_back(w);
    endfunction

    // Expected byte writes of read_string; returns consumed count and whether a NUL is written.
    function automatic void model_str(input logic [31:0] a, input logic [31:0] len,
                                      input logic [7:0] s[$], output int consumed,
                                      output int nul);
        longint n = longint'($signed(len));
        longint remain;
        int     i = 0;
        logic [7:0] c;
        consumed = 0; nul = 0;
        if (n > 1024) n = 1024;
        if (n <= 0) return;
        remain = n - 1;
        while (remain > 0 && i < s.size()) begin
            c = s[i]; i++;
            push_wr(a, c);
            a = a + 32'd1;
            remain--;
            if (c == 8'h0A) break;
        end
        push_wr(a, 8'h00);
        consumed = i; nul = 1;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_mem_we", {31'd0, mem_we}, 32'd0);
            end else begin
                e = exp_wr.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_be", {28'd0, mem_be}, {28'd0, e.be});
                check("mem_wdata", mem_wdata, e.data);
            end
            if (rf_we === 1'b1) check("we_overlap", {31'd0, rf_we}, 32'd0);
        end
        if (rf_we === 1'b1) begin
            last_rf = rf_wdata;
            if (exp_rf.size() == 0) check("unexpected_rf_we", {31'd0, rf_we}, 32'd0);
            else check("rf_wdata", rf_wdata, exp_rf.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic load(input string str);
        rx_q.delete();
        for (int k = 0; k < str.len(); k++) rx_q.push_back(str[k]);
    endtask

    task automatic present(input int idle);
        rx_valid = (rx_q.size() > 0) && (idle == 0);
        rx_data  = rx_valid ? rx_q[0] : 8'h00;
    endtask

    // Issues one syscall and runs until stall drops; gap = idle cycles after sys.
    task automatic run_sys(input logic [31:0] v, input logic [31:0] a, input logic [31:0] a1,
                           input int gap, output int stall_cycles);
        int   idle;
        int   budget;
        logic acc;
        @(posedge clk); #1;
        sys = 1'b1; regv = v; rega = a; rega1 = a1;
        idle = gap + 1;
        present(idle);
        stall_cycles = 0;
        for (budget = 0; budget < 300; budget++) begin
            @(negedge clk);
            acc = rx_valid && rx_ready;
            if (!stall) break;
            stall_cycles++;
            @(posedge clk); #1;
            sys = 1'b0;
            if (acc) void'(rx_q.pop_front());
            if (idle > 0) idle--;
            present(idle);
        end
        if (budget >= 300) begin
            checks++; failures++;
            $display("FAIL timeout stall still high after %0d cycles (required release)", budget);
        end
        @(posedge clk); #1;
        sys = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctrl"}, {26'd0, busy, stall, rx_ready, mem_we, rf_we, 1'b0}, 32'd0);
        check({name, "_data"}, mem_addr | mem_wdata | rf_wdata | {28'd0, mem_be}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sc, cons, nul;
        logic [31:0] res;
        logic [7:0]  cpy[$];

        reset = 1'b1; sys = 1'b0; regv = 0; rega = 0; rega1 = 0;
        rx_data = 0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1; reset = 1'b0;

        // read_int with leading whitespace and sign
        load(" \n-123\n"); cpy = rx_q;
        model_int(cpy, cons, res);
        check("pin_int_model_res", res, 32'hFFFF_FF85);
        check("pin_int_model_cons", cons, 32'd7);
        exp_rf.push_back(res);
        run_sys(32'd5, 32'd0, 32'd0, 0, sc);
        check("int_stall", sc, 32'd9);
        check("int_stall_model", sc, 32'(cons + 2));
        check("int_left", rx_q.size(), 32'd0);
        check("int_rf_literal", last_rf, 32'hFFFF_FF85);

        // read_string length cap: "hello", len 5, unaligned buffer
        load("hello"); cpy = rx_q;
        model_str(32'h1001_0001, 32'd5, cpy, cons, nul);
        check("pin_str_nwr", exp_wr.size(), 32'd5);
        check("pin_str_addr0", exp_wr[0].addr, 32'h1001_0000);
        check("pin_str_be0", {28'd0, exp_wr[0].be}, 32'd2);
        check("pin_str_nul_be", {28'd0, exp_wr[4].be}, 32'd2);
        run_sys(32'd8, 32'h1001_0001, 32'd5, 0, sc);
        check("str_stall", sc, 32'd7);
        check("str_left", rx_q.size(), 32'd1);
        check("str_pending", exp_wr.size(), 32'd0);

        // read_string terminated by newline
        load("ab\nzz"); cpy = rx_q;
        model_str(32'h2000_0010, 32'd10, cpy, cons, nul);
        check("pin_nl_data", exp_wr[2].data, 32'h0A0A_0A0A);
        run_sys(32'd8, 32'h2000_0010, 32'd10, 0, sc);
        check("nl_stall", sc, 32'(1 + cons + nul + 1));
        check("nl_left", rx_q.size(), 32'd2);
        check("nl_pending", exp_wr.size(), 32'd0);

        // read_char after idle gap
        load("A");
        exp_rf.push_back(32'h0000_0041);
        run_sys(32'd12, 32'd0, 32'd0, 3, sc);
        check("chr_stall", sc, 32'd6);
        check("chr_rf_literal", last_rf, 32'h0000_0041);

        // zero and negative length: no writes
        load("xy");
        run_sys(32'd8, 32'h3000_0000, 32'd0, 0, sc);
        check("len0_stall", sc, 32'd2);
        run_sys(32'd8, 32'h3000_0000, 32'hFFFF_FFFD, 0, sc);
        check("lenneg_stall", sc, 32'd2);
        check("len0_left", rx_q.size(), 32'd2);

        // length 1: NUL only
        cpy = rx_q;
        model_str(32'h3000_0002, 32'd1, cpy, cons, nul);
        run_sys(32'd8, 32'h3000_0002, 32'd1, 0, sc);
        check("len1_stall", sc, 32'd3);
        check("len1_left", rx_q.size(), 32'd2);
        check("len1_pending", exp_wr.size(), 32'd0);

        // unrelated code ignored
        run_sys(32'd4, 32'h4000_0000, 32'd3, 0, sc);
        check("other_stall", sc, 32'd0);
        check("other_left", rx_q.size(), 32'd2);

        // overflow wraps modulo 2^32
        load("4294967297 "); cpy = rx_q;
        model_int(cpy, cons, res);
        check("pin_ovf_model", res, 32'd1);
        exp_rf.push_back(res);
        run_sys(32'd5, 32'd0, 32'd0, 0, sc);
        check("ovf_stall", sc, 32'd13);
        check("ovf_rf_literal", last_rf, 32'd1);

        // '-' followed by a non-digit yields 0
        load("-x"); cpy = rx_q;
        model_int(cpy, cons, res);
        exp_rf.push_back(res);
        last_rf = 32'hDEAD_BEEF;
        run_sys(32'd5, 32'd0, 32'd0, 0, sc);
        check("negx_rf_literal", last_rf, 32'd0);
        check("negx_stall", sc, 32'd4);

        // asynchronous reset in the middle of a string
        load("ab");
        push_wr(32'h2000_0003, "a");
        push_wr(32'h2000_0004, "b");
        @(posedge clk); #1;
        sys = 1'b1; regv = 32'd8; rega = 32'h2000_0003; rega1 = 32'd10;
        present(0);
        for (int k = 0; k < 4; k++) begin
            logic acc;
            @(negedge clk);
            acc = rx_valid && rx_ready;
            @(posedge clk); #1;
            sys = 1'b0;
            if (acc) void'(rx_q.pop_front());
            present(0);
        end
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("rst_mid");
        check("rst_pending", exp_wr.size(), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        repeat (3) @(posedge clk);

        load("Z");
        exp_rf.push_back(32'h0000_005A);
        run_sys(32'd12, 32'd0, 32'd0, 0, sc);
        check("post_rst_stall", sc, 32'd3);
        check("post_rst_rf", last_rf, 32'h0000_005A);
        check("final_rf_pending", exp_rf.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
